// File: rtl/acc_pkg.sv
// Shared definitions for the 5-bit-address accumulator core:
// widths, opcodes and fetch state encodings.
package acc_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;

  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_ADD   = 3'b001;
  localparam logic [2:0] OP_SUB   = 3'b010;
  localparam logic [2:0] OP_STORE = 3'b011;
  localparam logic [2:0] OP_JMP   = 3'b100;
  localparam logic [2:0] OP_JZ    = 3'b101;
  localparam logic [2:0] OP_NOP   = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_MEMWAIT,
    S_HALT
  } fetch_state_t;

  function automatic logic is_mem_op(input logic [2:0] opc);
    return ~opc[2];
  endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC and memory-flag selection for one issued instruction.
// wrap flags a sequential increment out of the top address.
module next_pc_sel
  import acc_pkg::*;
(
  input  logic [2:0]        opc,
  input  logic [ADDR_W-1:0] arg,
  input  logic [ADDR_W-1:0] pc_cur,
  input  logic              acc_zero,
  output logic [ADDR_W-1:0] pc_next,
  output logic              rmem_next,
  output logic              halt_req,
  output logic              wrap
);

  localparam logic [ADDR_W-1:0] ONE = 1;

  logic [ADDR_W-1:0] pc_inc;
  logic              at_top;

  assign pc_inc = pc_cur + ONE;
  assign at_top = &pc_cur;

  always_comb begin
    pc_next   = pc_cur;
    rmem_next = 1'b0;
    halt_req  = 1'b0;
    wrap      = 1'b0;
    unique case (1'b1)
      is_mem_op(opc): begin
        pc_next   = pc_inc;
        rmem_next = 1'b1;
        wrap      = at_top;
      end
      (opc == OP_JMP): begin
        pc_next = arg;
      end
      (opc == OP_JZ): begin
        if (acc_zero) begin
          pc_next = arg;
        end else begin
          pc_next = pc_inc;
          wrap    = at_top;
        end
      end
      (opc == OP_NOP): begin
        pc_next = pc_inc;
        wrap    = at_top;
      end
      default: begin
        halt_req = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: fetch, issue, yield after memory ops.
// FETCH_WRAP_HALT_EN: halt instead of wrapping a sequential PC past 31.
module fetch_ctrl
  import acc_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_cur_i,
  input  logic              rmem_cur_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              rmem_o,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_ack_i,
  input  logic [DATA_W-1:0] imem_data_i,
  input  logic              acc_zero_i,
  output logic              ins_valid_o,
  input  logic              ins_ready_i,
  output logic [2:0]        ins_opc_o,
  output logic [ADDR_W-1:0] ins_arg_o,
  output logic              halted_o
);

`ifdef FETCH_WRAP_HALT_EN
  localparam bit WRAP_HALT = 1'b1;
`else
  localparam bit WRAP_HALT = 1'b0;
`endif

  fetch_state_t      state;
  logic [DATA_W-1:0] ir;
  logic              wrap_pend;

  logic [ADDR_W-1:0] sel_pc;
  logic              sel_rmem;
  logic              sel_halt;
  logic              sel_wrap;
  logic              wrap_stop;
  logic              hs;

  assign ins_opc_o   = ir[DATA_W-1:ADDR_W];
  assign ins_arg_o   = ir[ADDR_W-1:0];
  assign imem_addr_o = pc_cur_i;
  // The shared port belongs to data memory while rmem_cur_i is high.
  assign imem_req_o  = (state == S_FETCH) && !rmem_cur_i;
  assign ins_valid_o = (state == S_ISSUE);
  assign halted_o    = (state == S_HALT);
  assign hs          = ins_valid_o && ins_ready_i;
  assign wrap_stop   = WRAP_HALT & sel_wrap;

  next_pc_sel u_sel (
    .opc       (ins_opc_o),
    .arg       (ins_arg_o),
    .pc_cur    (pc_cur_i),
    .acc_zero  (acc_zero_i),
    .pc_next   (sel_pc),
    .rmem_next (sel_rmem),
    .halt_req  (sel_halt),
    .wrap      (sel_wrap)
  );

  always_comb begin
    pc_o   = pc_cur_i;
    rmem_o = 1'b0;
    if (hs && !wrap_stop) begin
      pc_o   = sel_pc;
      rmem_o = sel_rmem;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      ir        <= '0;
      wrap_pend <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: state <= S_FETCH;
        S_FETCH: begin
          if (imem_req_o && imem_ack_i) begin
            ir    <= imem_data_i;
            state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (ins_ready_i) begin
            wrap_pend <= wrap_stop;
            if (sel_halt || (wrap_stop && !sel_rmem))
              state <= S_HALT;
            else if (sel_rmem)
              state <= S_MEMWAIT;
            else
              state <= S_FETCH;
          end
        end
        S_MEMWAIT: state <= wrap_pend ? S_HALT : S_FETCH;
        S_HALT:    state <= S_HALT;
        default:   state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: an ISA-level interpreter predicts
// every issued instruction; a monitor checks each issue handshake.
module tb_fetch_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] pc_cur_i;
  logic       rmem_cur_i;
  logic [4:0] pc_o;
  logic       rmem_o;
  logic       imem_req_o;
  logic [4:0] imem_addr_o;
  logic       imem_ack_i = 1'b0;
  logic [7:0] imem_data_i = 8'h00;
  logic       acc_zero_i = 1'b0;
  logic       ins_valid_o;
  logic       ins_ready_i = 1'b0;
  logic [2:0] ins_opc_o;
  logic [4:0] ins_arg_o;
  logic       halted_o;

  fetch_ctrl dut (
    .clock       (clock),
    .reset       (reset),
    .pc_cur_i    (pc_cur_i),
    .rmem_cur_i  (rmem_cur_i),
    .pc_o        (pc_o),
    .rmem_o      (rmem_o),
    .imem_req_o  (imem_req_o),
    .imem_addr_o (imem_addr_o),
    .imem_ack_i  (imem_ack_i),
    .imem_data_i (imem_data_i),
    .acc_zero_i  (acc_zero_i),
    .ins_valid_o (ins_valid_o),
    .ins_ready_i (ins_ready_i),
    .ins_opc_o   (ins_opc_o),
    .ins_arg_o   (ins_arg_o),
    .halted_o    (halted_o)
  );

  always #5 clock = ~clock;

  // PC register downstream of the controller
  always @(posedge clock) begin
    if (reset) begin
      pc_cur_i   <= '0;
      rmem_cur_i <= 1'b0;
    end else begin
      pc_cur_i   <= pc_o;
      rmem_cur_i <= rmem_o;
    end
  end

  typedef struct {
    int pc;
    int opc;
    int arg;
    int pnext;
    int rmem;
    int halt;
  } exp_t;

  exp_t       q[$];
  logic [7:0] mem[32];
  bit         zseq[64];
  int         idx = 0;
  bit         armed = 0;
  int         ready_pct = 100;
  int         checks = 0;
  int         failures = 0;
  bit         last_halt;
  int         halt_pc;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ISA-level interpreter producing the expected issue sequence
  task automatic build_trace(input int limit);
    int pc;
    q.delete();
    last_halt = 0;
    pc = 0;
    for (int k = 0; k < limit; k++) begin
      exp_t e;
      bit   seq;
      e.pc   = pc;
      e.opc  = int'(mem[pc][7:5]);
      e.arg  = int'(mem[pc][4:0]);
      e.rmem = 0;
      e.halt = 0;
      seq    = 0;
      case (e.opc)
        7: begin e.pnext = pc; e.halt = 1; end
        4: e.pnext = e.arg;
        5: begin
          if (zseq[k]) e.pnext = e.arg;
          else begin e.pnext = pc + 1; seq = 1; end
        end
        6: begin e.pnext = pc + 1; seq = 1; end
        default: begin e.pnext = pc + 1; e.rmem = 1; seq = 1; end
      endcase
`ifdef FETCH_WRAP_HALT_EN
      if (seq && pc == 31) begin
        e.pnext = 31;
        e.rmem  = 0;
        e.halt  = 1;
      end
`endif
      e.pnext = e.pnext % 32;
      q.push_back(e);
      if (e.halt) begin
        last_halt = 1;
        halt_pc   = pc;
        break;
      end
      pc = e.pnext;
    end
  endtask

  // Stimulus drivers: ready, acc_zero and a memory with random latency
  int wcnt = 0;
  bit mreq_prev = 0;
  always @(posedge clock) begin
    #1;
    ins_ready_i = ($urandom_range(0, 99) < ready_pct);
    acc_zero_i  = zseq[idx];
    if (reset) begin
      imem_ack_i = 1'b0;
      mreq_prev  = 0;
    end else if (imem_req_o) begin
      if (!mreq_prev) wcnt = $urandom_range(0, 3);
      if (wcnt == 0) begin
        imem_ack_i  = 1'b1;
        imem_data_i = mem[imem_addr_o];
      end else begin
        imem_ack_i  = 1'b0;
        imem_data_i = 8'($urandom);
        wcnt--;
      end
      mreq_prev = 1;
    end else begin
      // stray acks outside a request must be ignored
      imem_ack_i  = ($urandom_range(0, 3) == 0);
      imem_data_i = 8'($urandom);
      mreq_prev   = 0;
    end
  end

  // Monitor
  bit         p_req = 0, p_valid = 0, p_ready = 0;
  logic [4:0] p_addr, p_arg;
  logic [2:0] p_opc;
  always @(negedge clock) begin
    if (reset) begin
      p_req   = 0;
      p_valid = 0;
      p_ready = 0;
    end else begin
      if (rmem_cur_i) begin
        chk("memwait_no_req", int'(imem_req_o), 0);
        chk("memwait_no_valid", int'(ins_valid_o), 0);
      end
      if (p_req && imem_req_o)
        chk("req_addr_stable", int'(imem_addr_o), int'(p_addr));
      if (imem_req_o)
        chk("addr_eq_pc", int'(imem_addr_o), int'(pc_cur_i));
      if (p_valid && !p_ready && ins_valid_o) begin
        chk("stall_opc_stable", int'(ins_opc_o), int'(p_opc));
        chk("stall_arg_stable", int'(ins_arg_o), int'(p_arg));
      end
      if (!ins_valid_o || !ins_ready_i)
        chk("pc_hold", int'(pc_o), int'(pc_cur_i));
      if (armed && ins_valid_o && ins_ready_i) begin
        if (q.size() == 0) begin
          chk("unexpected_issue", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("issue_pc", int'(pc_cur_i), e.pc);
          chk("issue_opc", int'(ins_opc_o), e.opc);
          chk("issue_arg", int'(ins_arg_o), e.arg);
          chk("pc_next", int'(pc_o), e.pnext);
          chk("rmem_next", int'(rmem_o), e.rmem);
          idx++;
          if (q.size() == 0) armed = 0;
        end
      end
      p_req   = imem_req_o;
      p_addr  = imem_addr_o;
      p_valid = ins_valid_o;
      p_ready = ins_ready_i;
      p_opc   = ins_opc_o;
      p_arg   = ins_arg_o;
    end
  end

  task automatic run_prog(input int limit);
    int t;
    @(posedge clock);
    #2;
    reset = 1'b1;
    armed = 0;
    idx   = 0;
    q.delete();
    @(posedge clock);
    @(negedge clock);
    chk("rst_req", int'(imem_req_o), 0);
    chk("rst_valid", int'(ins_valid_o), 0);
    chk("rst_opc", int'(ins_opc_o), 0);
    chk("rst_arg", int'(ins_arg_o), 0);
    chk("rst_halted", int'(halted_o), 0);
    chk("rst_rmem", int'(rmem_o), 0);
    chk("rst_pc", int'(pc_o), 0);
    chk("rst_addr", int'(imem_addr_o), 0);
    @(posedge clock);
    #2;
    build_trace(limit);
    armed = 1;
    reset = 1'b0;
    t = 0;
    while (q.size() != 0 && t < 3000) begin
      @(negedge clock);
      t++;
    end
    chk("trace_timeout", int'(q.size() != 0), 0);
    armed = 0;
    if (last_halt && q.size() == 0) begin
      t = 0;
      while (!halted_o && t < 4) begin
        @(negedge clock);
        t++;
      end
      chk("halted_rise", int'(halted_o), 1);
      repeat (20) begin
        @(negedge clock);
        chk("halt_no_req", int'(imem_req_o), 0);
        chk("halt_pc_held", int'(pc_o), halt_pc);
        chk("halt_stays", int'(halted_o), 1);
      end
    end else begin
      // leave the core running so the next reset lands mid-operation
      repeat ($urandom_range(0, 6)) @(posedge clock);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // NOP, JMP, ADD 5, JZ 9 taken, JZ 9 untaken, JMP 31, NOP at 31
    for (int i = 0; i < 32; i++) mem[i] = 8'hC0;
    for (int i = 0; i < 64; i++) zseq[i] = 0;
    mem[1]  = 8'h82;
    mem[2]  = 8'h25;
    mem[3]  = 8'hA9;
    mem[9]  = 8'hA9;
    mem[10] = 8'h9F;
    zseq[3] = 1;
    ready_pct = 100;
    run_prog(9);
    ready_pct = 35;
    run_prog(9);

    for (int p = 0; p < 14; p++) begin
      for (int i = 0; i < 32; i++) begin
        logic [2:0] o;
        o = 3'($urandom_range(0, 7));
        if (o == 3'd7 && $urandom_range(0, 3) != 0) o = 3'd6;
        mem[i] = {o, 5'($urandom)};
      end
      for (int i = 0; i < 64; i++) zseq[i] = 1'($urandom);
      ready_pct = $urandom_range(30, 100);
      run_prog(40);
    end

    for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
    mem[0] = 8'hE0;
    ready_pct = 60;
    run_prog(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
